// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path constants and the branch target helper
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP = 4;
  localparam int PC_PIPE_OFFSET = 8;
  function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [23:0] imm);
    return pc + 64'(PC_PIPE_OFFSET) + {{38{imm[23]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with flush, holding {pc, instr}
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (!nreset || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch into a decoupling queue with branch redirect
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               nreset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [23:0]        br_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] pc, inflight_pc, target;
  logic inflight, pop;
  logic [CW-1:0] count;
  logic [ADDR_W+INSTR_W-1:0] head;
  assign target = ADDR_W'(branch_target(64'(br_pc), br_imm));
  assign out_valid = nreset && count != '0;
  assign pop = out_valid && out_ready;
  // The slot freed by this cycle's pop is credited so a DEPTH=2 queue streams at full rate
  assign imem_req = nreset && !br_valid && (count + CW'(inflight) < CW'(DEPTH) + CW'(pop));
  assign imem_addr = pc;
  assign {out_pc, out_instr} = out_valid ? head : '0;
  always_ff @(posedge clk)
    if (!nreset) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= imem_req;
      inflight_pc <= pc;
      pc <= br_valid ? target : imem_req ? pc + ADDR_W'(PC_STEP) : pc;
    end
  // A redirect flushes the queue and drops the response arriving this cycle
  fetch_fifo #(.W(ADDR_W + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .nreset(nreset),
    .flush(br_valid),
    .push(inflight && !br_valid),
    .wdata({inflight_pc, imem_rdata}),
    .pop(pop),
    .rdata(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: branch vector table plus scoreboard of expected fetch stream
module tb_fetch_unit;
  logic clk = 0, nreset, imem_req, br_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, br_pc, out_instr, out_pc;
  logic [23:0] br_imm;
  int vectors = 0, miscompares = 0, reqs;
  logic [31:0] exp_q[$];
  typedef struct packed {
    logic [31:0] pc;
    logic [23:0] imm;
    logic [31:0] exp;
  } br_vec_t;
  br_vec_t vecs[7];

  fetch_unit dut (
    .clk(clk), .nreset(nreset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .br_valid(br_valid), .br_pc(br_pc), .br_imm(br_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (nreset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_transfer: got pc %h expected none", out_pc);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_instr", out_instr, word(e));
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h20, 24'h000002, 32'h30};
    vecs[1] = '{32'h20, 24'hFFFFFE, 32'h20};
    vecs[2] = '{32'h100, 24'h000000, 32'h108};
    vecs[3] = '{32'h0, 24'hFFFFFF, 32'h4};
    vecs[4] = '{32'hFFFF_FFF0, 24'h000001, 32'hFFFF_FFFC};
    vecs[5] = '{32'h1000, 24'h800000, 32'hFE00_1008};
    vecs[6] = '{32'h40, 24'h7FFFFF, 32'h0200_0044};
    nreset = 0; out_ready = 0; br_valid = 0; br_pc = 0; br_imm = 0;
    repeat (2) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    // streaming after release
    refill(0); nreset = 1; out_ready = 1; #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    chk("fill0_valid", out_valid, 0);
    tick();
    chk("fill1_valid", out_valid, 0);
    chk("second_addr", imem_addr, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'(4 * i));
      tick();
    end
    // stall with full queue
    nreset = 0; tick();
    nreset = 1; out_ready = 0; refill(0); reqs = 0; #1;
    for (int i = 0; i < 10; i++) begin
      reqs += int'(imem_req);
      if (i >= 5) chk("stall_hold_pc", out_pc, 0);
      tick();
    end
    chk("stall_reqs", reqs, 4);
    chk("stall_valid", out_valid, 1);
    chk("stall_req_low", imem_req, 0);
    out_ready = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_pc", out_pc, 32'(4 * i));
      tick();
    end
    // branch vectors while streaming
    foreach (vecs[v]) begin
      br_valid = 1; br_pc = vecs[v].pc; br_imm = vecs[v].imm; #1;
      chk("br_req_low", imem_req, 0);
      tick();
      br_valid = 0; refill(vecs[v].exp); #1;
      chk("br_next_valid", out_valid, 0);
      chk("br_next_req", imem_req, 1);
      chk("br_next_addr", imem_addr, vecs[v].exp);
      tick();
      chk("br_gap_valid", out_valid, 0);
      tick();
      chk("br_tgt_valid", out_valid, 1);
      chk("br_tgt_pc", out_pc, vecs[v].exp);
      repeat (3) tick();
    end
    // reset with a full queue
    out_ready = 0; #1;
    repeat (6) tick();
    chk("full_before_rst", out_valid, 1);
    nreset = 0; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_instr", out_instr, 0);
    chk("midrst_req", imem_req, 0);
    tick();
    nreset = 1; out_ready = 1; refill(0); #1;
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    chk("post_rst_valid", out_valid, 0);
    tick();
    chk("post_rst_fill", out_valid, 0);
    tick();
    chk("post_rst_first", out_pc, 0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
